// File: rtl/pipe_stall_sequencer_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        PS_INIT     = 2'd0,
        PS_RUN      = 2'd1,
        PS_MEM_WAIT = 2'd2,
        PS_TRAP     = 2'd3
    } ps_state_t;

    // Default parameter values
    localparam int unsigned PS_RST_FLUSH_CYCLES_DEF = 3;
    localparam int unsigned PS_MEM_TIMEOUT_DEF      = 255;
    localparam int unsigned PS_CNT_W_DEF            = 32;

    // Per-stage register enables and bubble clears
    typedef struct packed {
        logic en_f;
        logic en_d;
        logic en_e;
        logic en_m;
        logic en_w;
        logic clr_d;
        logic clr_e;
        logic clr_m;
    } ps_ctrl_t;

    // Whole pipe frozen, nothing cleared
    localparam ps_ctrl_t PS_CTRL_FREEZE = 8'b00000_000;
    // Whole pipe frozen and all bubble clears asserted (INIT/TRAP)
    localparam ps_ctrl_t PS_CTRL_FLUSH  = 8'b00000_111;
    // Free-running pipe
    localparam ps_ctrl_t PS_CTRL_RUN    = 8'b11111_000;
    // Taken branch: everything advances, D and E become bubbles
    localparam ps_ctrl_t PS_CTRL_BRANCH = 8'b11111_110;
    // Load-use: F/D hold, a bubble enters E
    localparam ps_ctrl_t PS_CTRL_LOAD   = 8'b00111_010;

    // Hazard decode with the memory term already resolved; branch beats load
    // because the instruction that would stall is flushed by the branch.
    function automatic ps_ctrl_t ps_run_decode(input logic load_stall, input logic pcsrc);
        ps_ctrl_t ctrl;
        if (pcsrc) begin
            ctrl = PS_CTRL_BRANCH;
        end else if (load_stall) begin
            ctrl = PS_CTRL_LOAD;
        end else begin
            ctrl = PS_CTRL_RUN;
        end
        return ctrl;
    endfunction

endpackage

// File: rtl/pipe_stall_sequencer_if.sv
// Hazard/memory requests into the sequencer and stage enables/clears out.
interface pipe_stall_sequencer_if;

    logic i_ps_LoadStall;
    logic i_ps_PCSrcE;
    logic i_ps_DmemReq;
    logic i_ps_DmemReady;

    logic o_ps_EnF;
    logic o_ps_EnD;
    logic o_ps_EnE;
    logic o_ps_EnM;
    logic o_ps_EnW;
    logic o_ps_ClrD;
    logic o_ps_ClrE;
    logic o_ps_ClrM;

    // Sequencer side
    modport slave (
        input  i_ps_LoadStall, i_ps_PCSrcE, i_ps_DmemReq, i_ps_DmemReady,
        output o_ps_EnF, o_ps_EnD, o_ps_EnE, o_ps_EnM, o_ps_EnW,
        output o_ps_ClrD, o_ps_ClrE, o_ps_ClrM
    );

    // Core/hazard-unit side
    modport master (
        output i_ps_LoadStall, i_ps_PCSrcE, i_ps_DmemReq, i_ps_DmemReady,
        input  o_ps_EnF, o_ps_EnD, o_ps_EnE, o_ps_EnM, o_ps_EnW,
        input  o_ps_ClrD, o_ps_ClrE, o_ps_ClrM
    );

endinterface

// File: rtl/pipe_stall_sequencer_event_counter.sv
// Wrapping event counter with synchronous clear and increment enable.
module event_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count qualified events, wrapping modulo 2^CNT_W; clear has priority
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stall_sequencer.sv
// Pipeline-control sequencer: merges load-use / branch hazards with the
// multi-cycle data-memory handshake, post-reset flush and timeout trap.
module pipe_stall_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned RST_FLUSH_CYCLES = PS_RST_FLUSH_CYCLES_DEF,
    parameter int unsigned MEM_TIMEOUT      = PS_MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W            = PS_CNT_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    pipe_stall_sequencer_if.slave  ps,
    output logic                   o_ps_Trap,
    output logic [CNT_W-1:0]       o_ps_StallCnt,
    output logic [CNT_W-1:0]       o_ps_FlushCnt
);

    localparam logic [3:0] FLUSH_LAST = 4'(RST_FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

    ps_state_t  r_state;
    logic [3:0] r_flush_cnt;
    logic [7:0] r_wait_cnt;
    logic       r_trap;

    ps_ctrl_t   w_ctrl;
    logic       w_mem_stall;
    logic       w_active;
    logic       w_stall_inc;
    logic       w_flush_inc;

    assign w_mem_stall = ps.i_ps_DmemReq && !ps.i_ps_DmemReady;

    // Mealy decode of enables/clears from current state and this cycle's requests
    always_comb begin
        w_ctrl = PS_CTRL_FLUSH;
        case (r_state)
            PS_INIT:     w_ctrl = PS_CTRL_FLUSH;
            PS_RUN:      w_ctrl = w_mem_stall ? PS_CTRL_FREEZE
                                              : ps_run_decode(ps.i_ps_LoadStall, ps.i_ps_PCSrcE);
            // On release the held hazard requests are honoured in the same cycle
            PS_MEM_WAIT: w_ctrl = ps.i_ps_DmemReady ? ps_run_decode(ps.i_ps_LoadStall, ps.i_ps_PCSrcE)
                                                    : PS_CTRL_FREEZE;
            PS_TRAP:     w_ctrl = PS_CTRL_FLUSH;
            default:     w_ctrl = PS_CTRL_FLUSH;
        endcase
    end

    // Only RUN/MEM_WAIT cycles are counted; INIT/TRAP clears are not branch flushes
    assign w_active    = (r_state == PS_RUN) || (r_state == PS_MEM_WAIT);
    assign w_stall_inc = w_active && !w_ctrl.en_f;
    assign w_flush_inc = w_active && w_ctrl.clr_d;

    // State register, flush/wait counters and sticky trap flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= PS_INIT;
            r_flush_cnt <= FLUSH_LAST;
            r_wait_cnt  <= '0;
            r_trap      <= 1'b0;
        end else begin
            case (r_state)
                PS_INIT: begin
                    if (r_flush_cnt == 4'd0) begin
                        r_state <= PS_RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end
                end
                PS_RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= PS_MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                PS_MEM_WAIT: begin
                    if (ps.i_ps_DmemReady) begin
                        r_state <= PS_RUN;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state <= PS_TRAP;
                        r_trap  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                PS_TRAP: begin
                    r_trap <= 1'b1;
                end
                default: begin
                    r_state     <= PS_INIT;
                    r_flush_cnt <= FLUSH_LAST;
                    r_wait_cnt  <= '0;
                end
            endcase
        end
    end

    assign ps.o_ps_EnF  = w_ctrl.en_f;
    assign ps.o_ps_EnD  = w_ctrl.en_d;
    assign ps.o_ps_EnE  = w_ctrl.en_e;
    assign ps.o_ps_EnM  = w_ctrl.en_m;
    assign ps.o_ps_EnW  = w_ctrl.en_w;
    assign ps.o_ps_ClrD = w_ctrl.clr_d;
    assign ps.o_ps_ClrE = w_ctrl.clr_e;
    assign ps.o_ps_ClrM = w_ctrl.clr_m;
    assign o_ps_Trap    = r_trap;

    event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_inc (w_stall_inc),
        .o_cnt (o_ps_StallCnt)
    );

    event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_inc (w_flush_inc),
        .o_cnt (o_ps_FlushCnt)
    );

endmodule

// File: tb/tb_pipe_stall_sequencer.sv
// Directed bench for pipe_stall_sequencer (RST_FLUSH_CYCLES=3, MEM_TIMEOUT=8, CNT_W=4).
module tb_pipe_stall_sequencer;

    logic       clk;
    logic       rst;
    logic       trap;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;
    int         n_checks;
    int         n_errors;

    pipe_stall_sequencer_if ps_bus ();

    pipe_stall_sequencer #(
        .RST_FLUSH_CYCLES (3),
        .MEM_TIMEOUT      (8),
        .CNT_W            (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .ps            (ps_bus),
        .o_ps_Trap     (trap),
        .o_ps_StallCnt (stall_cnt),
        .o_ps_FlushCnt (flush_cnt)
    );

    logic [4:0] en;
    logic [2:0] clr;
    assign en  = {ps_bus.o_ps_EnF, ps_bus.o_ps_EnD, ps_bus.o_ps_EnE, ps_bus.o_ps_EnM, ps_bus.o_ps_EnW};
    assign clr = {ps_bus.o_ps_ClrD, ps_bus.o_ps_ClrE, ps_bus.o_ps_ClrM};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic br, input logic req, input logic rdy);
        ps_bus.i_ps_LoadStall = ld;
        ps_bus.i_ps_PCSrcE    = br;
        ps_bus.i_ps_DmemReq   = req;
        ps_bus.i_ps_DmemReady = rdy;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0);

        // Reset held two cycles
        tick();
        tick();
        settle();
        chk("rst_en", 32'(en), 32'h00);
        chk("rst_clr", 32'(clr), 32'h7);
        chk("rst_trap", 32'(trap), 32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        chk("rst_flush", 32'(flush_cnt), 32'h0);
        rst = 1'b0;

        // Three flush cycles, then RUN
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("flush_en", 32'(en), 32'h00);
            chk("flush_clr", 32'(clr), 32'h7);
            tick();
        end
        settle();
        chk("run_en", 32'(en), 32'h1f);
        chk("run_clr", 32'(clr), 32'h0);

        // Load-use stall
        drive(1, 0, 0, 0);
        settle();
        chk("load_en", 32'(en), 32'h07);
        chk("load_clr", 32'(clr), 32'h2);
        tick();
        drive(0, 0, 0, 0);
        settle();
        chk("load_stallcnt", 32'(stall_cnt), 32'h1);
        chk("load_flushcnt", 32'(flush_cnt), 32'h0);
        chk("load_after_en", 32'(en), 32'h1f);

        // Branch overrides simultaneous load
        drive(1, 1, 0, 0);
        settle();
        chk("br_en", 32'(en), 32'h1f);
        chk("br_clr", 32'(clr), 32'h6);
        tick();
        drive(0, 0, 0, 0);
        settle();
        chk("br_flushcnt", 32'(flush_cnt), 32'h1);
        chk("br_stallcnt", 32'(stall_cnt), 32'h1);

        // Zero-wait memory access
        drive(0, 0, 1, 1);
        settle();
        chk("zw_en", 32'(en), 32'h1f);
        tick();
        drive(0, 0, 0, 0);
        settle();
        chk("zw_stallcnt", 32'(stall_cnt), 32'h1);

        // Memory wait, ready after 4 cycles
        drive(0, 0, 1, 0);
        settle();
        chk("mw_t_en", 32'(en), 32'h00);
        chk("mw_t_clr", 32'(clr), 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mw_wait_en", 32'(en), 32'h00);
            tick();
        end
        drive(0, 0, 1, 1);
        settle();
        chk("mw_rel_en", 32'(en), 32'h1f);
        chk("mw_rel_clr", 32'(clr), 32'h0);
        tick();
        drive(0, 0, 0, 0);
        settle();
        chk("mw_stallcnt", 32'(stall_cnt), 32'h5);
        chk("mw_back_run", 32'(en), 32'h1f);

        // Memory wait with held load-use honoured on release
        drive(1, 0, 1, 0);
        settle();
        chk("mwl_t_en", 32'(en), 32'h00);
        tick();
        drive(1, 0, 1, 1);
        settle();
        chk("mwl_rel_en", 32'(en), 32'h07);
        chk("mwl_rel_clr", 32'(clr), 32'h2);
        tick();
        drive(0, 0, 0, 0);
        settle();
        chk("mwl_stallcnt", 32'(stall_cnt), 32'h7);
        chk("mwl_flushcnt", 32'(flush_cnt), 32'h1);

        // Timeout: request at t, no ready, trap at t+9
        drive(0, 0, 1, 0);
        settle();
        chk("to_t_trap", 32'(trap), 32'h0);
        tick();
        for (int i = 1; i <= 8; i++) begin
            settle();
            chk("to_wait_trap", 32'(trap), 32'h0);
            chk("to_wait_en", 32'(en), 32'h00);
            tick();
        end
        settle();
        chk("to_trap", 32'(trap), 32'h1);
        chk("to_trap_en", 32'(en), 32'h00);
        chk("to_trap_clr", 32'(clr), 32'h7);
        chk("to_stallcnt", 32'(stall_cnt), 32'h0);
        chk("to_flushcnt", 32'(flush_cnt), 32'h1);
        for (int i = 0; i < 4; i++) begin
            drive(logic'(i & 1), logic'(~i & 1), 1'b1, logic'((i >> 1) & 1));
            settle();
            chk("trap_sticky", 32'(trap), 32'h1);
            chk("trap_sticky_en", 32'(en), 32'h00);
            tick();
        end
        settle();
        chk("trap_stallcnt", 32'(stall_cnt), 32'h0);
        chk("trap_flushcnt", 32'(flush_cnt), 32'h1);

        // Reset clears trap and counters
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        settle();
        chk("rst2_trap", 32'(trap), 32'h0);
        chk("rst2_stall", 32'(stall_cnt), 32'h0);
        chk("rst2_flush", 32'(flush_cnt), 32'h0);
        chk("rst2_en", 32'(en), 32'h00);
        tick();
        tick();
        tick();
        settle();
        chk("rst2_run_en", 32'(en), 32'h1f);

        // StallCnt wrap with CNT_W=4
        drive(1, 0, 0, 0);
        repeat (15) tick();
        settle();
        chk("wrap_15", 32'(stall_cnt), 32'hf);
        tick();
        settle();
        chk("wrap_0", 32'(stall_cnt), 32'h0);
        drive(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stall_sequencer.md
# pipe_stall_sequencer

Registered pipeline-control sequencer for the 5-stage RV32I core. Merges the combinational hazard requests (load-use stall, taken branch/jump) with the multi-cycle data-memory handshake, a post-reset flush sequence and a memory-timeout trap. Produces the per-stage register enables and clears used by the F/D/E/M/W pipeline registers. Also keeps stall and flush event counters for performance monitoring.

## Interface
- `RST_FLUSH_CYCLES`, default 3: number of cycles all stages are held cleared after reset (valid range 1..15).
- `MEM_TIMEOUT`, default 255: maximum number of MEM_WAIT cycles without ready before a trap (valid range 1..255).
- `CNT_W`, default 32: width of the event counters.
- `i_clk` input 1: core clock, rising edge.
- `i_rst` input 1: **synchronous, active-high reset; one clock domain (`i_clk`).**
- `i_ps_LoadStall` input 1: load-use hazard request from the hazard unit.
- `i_ps_PCSrcE` input 1: taken branch or jump in E.
- `i_ps_DmemReq` input 1: the M-stage instruction accesses data memory this cycle.
- `i_ps_DmemReady` input 1: data memory has completed the access this cycle.
- `o_ps_EnF`, `o_ps_EnD`, `o_ps_EnE`, `o_ps_EnM`, `o_ps_EnW` output 1 each: pipeline-register load enables.
- `o_ps_ClrD`, `o_ps_ClrE`, `o_ps_ClrM` output 1 each: synchronous bubble insertion into the D/E/M registers.
- `o_ps_Trap` output 1: memory timeout; sticky until reset.
- `o_ps_StallCnt` output CNT_W: count of cycles in which F was stalled (load or memory).
- `o_ps_FlushCnt` output CNT_W: count of cycles with `o_ps_ClrD` due to a branch.

## Operation
- States are INIT, RUN, MEM_WAIT and TRAP. The state register and counters are sequential; outputs are Mealy, decoded from the current state plus the current-cycle inputs, so hazard response is zero-latency.
- **INIT** (entered on reset):
  - All enables are 0; ClrD, ClrE and ClrM are 1.
  - A down-counter loads RST_FLUSH_CYCLES−1 and decrements each cycle.
  - At 0 the FSM moves to RUN on the next edge.
- **RUN**, with priority memory > branch > load:
  - **DmemReq=1 and DmemReady=0:** all enables 0, no clears; next state is MEM_WAIT and the wait counter is cleared to 0.
  - **DmemReq=1 and DmemReady=1:** zero-wait access, handled as if no request.
  - **PCSrcE=1:** all enables 1; ClrD=ClrE=1. This overrides a simultaneous LoadStall, because the stalled instruction is flushed anyway.
  - **LoadStall=1 (no branch):** EnF=EnD=0, EnE=EnM=EnW=1, ClrE=1.
  - **Otherwise:** all enables 1, no clears.
- **MEM_WAIT**:
  - **No ready:** all enables 0, no clears. The wait counter increments. When the counter already equals MEM_TIMEOUT−1 and ready is still 0, the next state is TRAP.
  - **DmemReady=1:** that same cycle is decoded exactly as RUN with the memory term removed, so a pending PCSrcE or LoadStall is honoured. Next state is RUN.
  - Requesters hold DmemReq, PCSrcE and LoadStall stable, because every stage is frozen.
- **TRAP**: all enables 0, ClrD=ClrE=ClrM=1, `o_ps_Trap`=1. Only `i_rst` exits this state.
- **Counters** wrap modulo 2^CNT_W:
  - `o_ps_StallCnt` += 1 in every RUN or MEM_WAIT cycle with EnF=0.
  - `o_ps_FlushCnt` += 1 in every cycle whose decode asserts ClrD.
  - Neither counter increments in INIT or TRAP.
- **Reset mid-operation:** `i_rst` wins over every state, including MEM_WAIT and TRAP. It returns the FSM to INIT and zeroes both counters and the wait counter. An outstanding memory access is abandoned.

## Timing
- Reset values, valid in the cycle after the `i_rst` edge and held for RST_FLUSH_CYCLES cycles:
  - State is INIT.
  - All `o_ps_En*` are 0 and all `o_ps_Clr*` are 1.
  - `o_ps_Trap`=0, `o_ps_StallCnt`=0, `o_ps_FlushCnt`=0.
- The first RUN cycle is RST_FLUSH_CYCLES cycles after reset deassertion.
- Enables and clears respond to inputs combinationally in the same cycle. State, counters and Trap update on the rising edge.
- A request issued in cycle t with ready arriving in cycle t+k (k≥1) gives k stall cycles before the release cycle t+k. StallCnt increases by k.
- With ready never arriving, MEM_WAIT lasts MEM_TIMEOUT cycles. Trap asserts at cycle t+MEM_TIMEOUT+1.

## Structure
- Package `pipe_ctrl_pkg`:
  - state enum `ps_state_t` (INIT, RUN, MEM_WAIT, TRAP)
  - default parameter constants
  - packed struct `ps_ctrl_t` bundling the enables and clears
- Sub-module `event_counter` (CNT_W wide, synchronous clear, increment-enable, wrapping) is instantiated twice.
- FSM and output decode live in the top module.

## Test plan
- **Reset flush:** assert `i_rst` 2 cycles. With RST_FLUSH_CYCLES=3, the 3 following cycles show all En=0 and all Clr=1. The 4th cycle shows all En=1. Counters read 0.
- **Load-use:** one cycle of LoadStall=1 gives EnF=EnD=0 and ClrE=1 in that cycle. StallCnt becomes 1 and FlushCnt stays 0.
- **Branch plus load:** PCSrcE=1 and LoadStall=1 in the same cycle give all En=1 and ClrD=ClrE=1. FlushCnt becomes 1 and StallCnt is unchanged.
- **Memory wait:** DmemReq=1 with ready raised after 4 cycles gives 4 all-zero-enable cycles, then a release cycle with all En=1. StallCnt=4 and the FSM is back in RUN.
- **Timeout:** MEM_TIMEOUT=8 with ready held 0 gives Trap=1 at cycle t+9. Trap stays 1 while PCSrcE, LoadStall and DmemReady toggle. `i_rst` clears it.
- **Wrap:** preload or drive StallCnt to 2^CNT_W−1 with CNT_W=4; one more stall cycle reads 0.
